// File: rtl/mem_op_arbiter.sv
// Purpose     : round-robin arbiter/sequencer sharing one on-chip memory port between NUM_REQ requesters.
// Latency     : request seen in IDLE at T -> op_enable at T+1; write ack at T+2; read ack+rdata one cycle after readValid.
// Backpressure: one command in flight; requesters hold req/command until ack, reads wait on op_readValid indefinitely.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req/req_write/req_addr/      per-requester request level, op (1=write), flattened
//   req_wdata                    address and write data (requester i at [i*W +: W])
//   ack, rdata, grant_id, busy   registered completion pulse, read word, last winner, not-idle flag
//   op_enable/op_write/op_addr/  memory port command, driven only during the single ISSUE cycle
//   op_writeData
//   op_readData/op_readValid     memory port read return
module mem_op_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int WORD_WIDTH = 256
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              ack,
  output logic [WORD_WIDTH-1:0]           rdata,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            op_enable,
  output logic                            op_write,
  output logic [ADDR_WIDTH-1:0]           op_addr,
  output logic [WORD_WIDTH-1:0]           op_writeData,
  input  logic [WORD_WIDTH-1:0]           op_readData,
  input  logic                            op_readValid
);

  localparam int             IDW     = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_R = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic                   cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
  logic [WORD_WIDTH-1:0]  cmd_wdata_q, cmd_wdata_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [WORD_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate the request vector so bit 0 is the requester at
  // ptr, take the lowest set bit, then map the offset back to an absolute index.
  // ---------------------------------------------------------------------------
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [2*NUM_REQ-1:0]   req_rot;
  logic [IDW:0]           win_sum;
  logic [IDW-1:0]         win_idx;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> ptr_q;

  always_comb begin
    win_sum = '0;
    // Descending scan so the lowest set offset is the last (winning) assignment.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req_rot[off]) begin
        win_sum = {1'b0, ptr_q} + (IDW+1)'(off);
      end
    end
    if (win_sum >= (IDW+1)'(NUM_REQ)) begin
      win_sum = win_sum - (IDW+1)'(NUM_REQ);
    end
    win_idx = win_sum[IDW-1:0];
  end

  // Command of the winning requester.
  logic                   sel_write;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [WORD_WIDTH-1:0]  sel_wdata;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|req) state_d = S_ISSUE;
      S_ISSUE:  state_d = cmd_write_q ? S_RESP : S_WAIT_R;
      S_WAIT_R: if (op_readValid) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The memory command comes only from state and the latched
  // copy, so nothing from req* reaches the memory port combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_enable    = 1'b0;
    op_write     = 1'b0;
    op_addr      = '0;
    op_writeData = '0;
    if (state_q == S_ISSUE) begin
      op_enable    = 1'b1;
      op_write     = cmd_write_q;
      op_addr      = cmd_addr_q;
      op_writeData = cmd_wdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_id_d  = grant_id_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    ptr_d       = ptr_q;
    rdata_d     = rdata_q;

    if (state_q == S_IDLE && |req) begin
      grant_id_d  = win_idx;
      cmd_write_d = sel_write;
      cmd_addr_d  = sel_addr;
      cmd_wdata_d = sel_wdata;
    end

    // Next search starts just past the requester being acknowledged.
    if (state_q == S_RESP) begin
      ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);
    end

    if (state_q == S_WAIT_R && op_readValid) begin
      rdata_d = op_readData;
    end

    // ack and busy are registered, so derive them from the state being entered.
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_d[i] = (state_d == S_RESP) && (grant_id_q == IDW'(i));
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      grant_id_q  <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_op_arbiter.sv
// Directed bench for mem_op_arbiter: a 2-requester instance with a simple
// memory model, and a 4-requester instance for the wrap-around case.
module tb_mem_op_arbiter;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 2-requester instance ----------------
  logic [1:0]   req2, wr2, ack2;
  logic [21:0]  addr2;
  logic [511:0] wdata2;
  logic [255:0] rdata2, owd2, ord2;
  logic         gid2, busy2, en2, we2, orv2;
  logic [10:0]  oaddr2;

  mem_op_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(11), .WORD_WIDTH(256)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .req(req2), .req_write(wr2), .req_addr(addr2), .req_wdata(wdata2),
    .ack(ack2), .rdata(rdata2), .grant_id(gid2), .busy(busy2),
    .op_enable(en2), .op_write(we2), .op_addr(oaddr2), .op_writeData(owd2),
    .op_readData(ord2), .op_readValid(orv2)
  );

  // Memory model: readValid one cycle after a read issue.
  logic [255:0] mem [64];
  logic         rv_model, mem_auto, rv_force;
  logic [255:0] rd_model, rd_force;

  always @(posedge clk) begin
    rv_model <= en2 && !we2;
    rd_model <= mem[oaddr2[5:0]];
    if (en2 && we2) mem[oaddr2[5:0]] <= owd2;
  end

  assign orv2 = mem_auto ? rv_model : rv_force;
  assign ord2 = mem_auto ? rd_model : rd_force;

  // ---------------- 4-requester instance ----------------
  logic [3:0]   req4, wr4, ack4;
  logic [43:0]  addr4;
  logic [127:0] wdata4;
  logic [31:0]  rdata4, owd4, ord4;
  logic [1:0]   gid4;
  logic         busy4, en4, we4, orv4;
  logic [10:0]  oaddr4;

  mem_op_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(11), .WORD_WIDTH(32)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .req(req4), .req_write(wr4), .req_addr(addr4), .req_wdata(wdata4),
    .ack(ack4), .rdata(rdata4), .grant_id(gid4), .busy(busy4),
    .op_enable(en4), .op_write(we4), .op_addr(oaddr4), .op_writeData(owd4),
    .op_readData(ord4), .op_readValid(orv4)
  );

  assign ord4 = 32'h0;
  always @(posedge clk) orv4 <= en4 && !we4;

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] W0 = {8{32'h1111_0000}};
  localparam logic [255:0] W1 = {8{32'h2222_0001}};

  initial begin
    reset_n  = 1'b0;
    req2 = '0; wr2 = '0; addr2 = '0; wdata2 = '0;
    req4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0;
    mem_auto = 1'b1; rv_force = 1'b0; rd_force = '0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_ack", ack2, 0);
    check("rst_busy", busy2, 0);
    check("rst_gid", gid2, 0);
    check("rst_rdata", rdata2, 0);
    check("rst_en", en2, 0);
    check("rst_we", we2, 0);
    check("rst_addr", oaddr2, 0);
    check("rst_wd", owd2, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- single write, requester 0 ----
    req2 = 2'b01; wr2[0] = 1'b1; addr2[10:0] = 11'h005; wdata2[255:0] = A5;
    @(negedge clk);  // T+1
    check("wr_en", en2, 1);
    check("wr_we", we2, 1);
    check("wr_addr", oaddr2, 11'h005);
    check("wr_wd", owd2, A5);
    check("wr_busy", busy2, 1);
    check("wr_ack_early", ack2, 0);
    @(negedge clk);  // T+2
    check("wr_ack", ack2, 2'b01);
    check("wr_en_off", en2, 0);
    req2 = 2'b00;
    @(negedge clk);  // T+3
    check("wr_busy_off", busy2, 0);
    check("wr_ack_off", ack2, 0);

    // ---- single read, requester 1 ----
    req2 = 2'b10; wr2[1] = 1'b0; addr2[21:11] = 11'h005;
    @(negedge clk);  // T+1
    check("rd_en", en2, 1);
    check("rd_we", we2, 0);
    check("rd_addr", oaddr2, 11'h005);
    check("rd_gid", gid2, 1);
    @(negedge clk);  // T+2
    check("rd_en_wait", en2, 0);
    check("rd_addr_wait", oaddr2, 0);
    check("rd_ack_wait", ack2, 0);
    check("rd_busy_wait", busy2, 1);
    @(negedge clk);  // T+3
    check("rd_ack", ack2, 2'b10);
    check("rd_data", rdata2, A5);
    req2 = 2'b00;
    @(negedge clk);
    check("rd_ack_off", ack2, 0);
    check("rd_busy_off", busy2, 0);

    // ---- reset in idle: ptr back to 0, rdata cleared ----
    reset_n = 1'b0;
    #1;
    check("rst2_rdata", rdata2, 0);
    check("rst2_gid", gid2, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- simultaneous writes held for 6 operations ----
    req2 = 2'b11; wr2 = 2'b11; addr2 = {11'h009, 11'h008}; wdata2 = {W1, W0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);  // issue cycle at T+1+3k
      check("sim_en", en2, 1);
      check("sim_gid", gid2, k % 2);
      check("sim_addr", oaddr2, (k % 2) ? 11'h009 : 11'h008);
      @(negedge clk);
      check("sim_ack", ack2, (k % 2) ? 2'b10 : 2'b01);
      if (k == 5) req2 = 2'b00;
      @(negedge clk);
      check("sim_idle", busy2, 0);
    end

    // ---- read back requester 1's word so rdata is non-zero ----
    req2 = 2'b10; wr2 = 2'b00; addr2[21:11] = 11'h009;
    @(negedge clk);
    check("rb_en", en2, 1);
    @(negedge clk);
    @(negedge clk);
    check("rb_ack", ack2, 2'b10);
    check("rb_data", rdata2, W1);
    req2 = 2'b00;
    @(negedge clk);

    // ---- command change and req drop after grant ----
    req2 = 2'b01; wr2 = 2'b01; addr2[10:0] = 11'h010; wdata2[255:0] = W0;
    @(negedge clk);  // T+1
    check("cc_en", en2, 1);
    check("cc_addr", oaddr2, 11'h010);
    addr2[10:0] = 11'h020; req2 = 2'b00;
    @(negedge clk);  // T+2
    check("cc_ack", ack2, 2'b01);
    check("cc_rdata_hold", rdata2, W1);
    @(negedge clk);
    check("cc_busy_off", busy2, 0);
    check("cc_rdata_hold2", rdata2, W1);

    // ---- reset in WAIT_R, late readValid ignored ----
    mem_auto = 1'b0;
    req2 = 2'b01; wr2 = 2'b00; addr2[10:0] = 11'h005;
    @(negedge clk);  // T+1
    check("mr_en", en2, 1);
    @(negedge clk);  // T+2, WAIT_R
    check("mr_busy", busy2, 1);
    reset_n = 1'b0;
    req2 = 2'b00;
    #1;
    check("mr_busy_rst", busy2, 0);
    check("mr_ack_rst", ack2, 0);
    check("mr_en_rst", en2, 0);
    check("mr_rdata_rst", rdata2, 0);
    check("mr_addr_rst", oaddr2, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rv_force = 1'b1; rd_force = A5;
    @(negedge clk);
    rv_force = 1'b0;
    check("mr_late_ack", ack2, 0);
    check("mr_late_busy", busy2, 0);
    check("mr_late_rdata", rdata2, 0);
    @(negedge clk);
    check("mr_late_ack2", ack2, 0);
    check("mr_late_rdata2", rdata2, 0);
    mem_auto = 1'b1;

    // ---- wrap-around on the 4-requester instance ----
    req4 = 4'b1001; wr4 = 4'b1111;
    addr4[10:0] = 11'h003; addr4[43:33] = 11'h030;
    wdata4[31:0] = 32'h0000_00C0; wdata4[127:96] = 32'h0000_00C3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wrap_en", en4, 1);
      check("wrap_gid", gid4, (k % 2) ? 2'd3 : 2'd0);
      check("wrap_addr", oaddr4, (k % 2) ? 11'h030 : 11'h003);
      check("wrap_wd", owd4, (k % 2) ? 32'h0000_00C3 : 32'h0000_00C0);
      @(negedge clk);
      check("wrap_ack", ack4, (k % 2) ? 4'b1000 : 4'b0001);
      if (k == 3) req4 = 4'b0000;
      @(negedge clk);
      check("wrap_idle", busy4, 0);
    end
    check("wrap_rdata", rdata4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
